// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   state_e : arbiter FSM states (IDLE/BUSY/DONE)
//   owner_e : which requester owns the current transaction
//   TIMEOUT_DEF : default BUSY-cycle limit before a transaction is aborted
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog counter for the memory arbiter.
// Ports:
//   clk, rst   : clock and synchronous active-low reset
//   clr_i      : clear the count (start of a transaction)
//   inc_i      : count one BUSY cycle that ended without mem_ready
//   expired_o  : this increment brings the count to TIMEOUT
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Flagged one cycle early so the FSM leaves BUSY on the edge where the
  // count would reach TIMEOUT, giving exactly TIMEOUT BUSY cycles.
  assign expired_o = inc_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch stage / data stage) for one shared memory port.
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   if_req/if_addr              : fetch read request (held until if_done)
//   if_done/if_rdata            : fetch completion pulse and read data
//   dm_req/dm_wr/dm_addr/dm_wdata : data-stage request (held until dm_done)
//   dm_done/dm_rdata            : data-stage completion pulse and read data
//   mem_en/mem_wr/mem_addr/mem_wdata : registered shared-memory request
//   mem_rdata/mem_ready         : memory read data and completion
//   if_stall/dm_stall           : req & ~done per requester
//   err                         : pulses with done when a transaction times out
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking; otherwise
// the data stage always wins a tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [DW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [DW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          if_stall,
  output logic          dm_stall,
  output logic          err
);

  // state | meaning
  // IDLE  | no transaction; grant on any request
  // BUSY  | memory access in flight, waiting for mem_ready or timeout
  // DONE  | owner's done (and err on timeout) high for this one cycle

  state_e          state_q;
  owner_e          owner_q;
  owner_e          grant_d;
  logic            mem_en_q, mem_wr_q;
  logic [DW-1:0]   mem_addr_q, mem_wdata_q;
  logic [DW-1:0]   if_rdata_q, dm_rdata_q;
  logic            if_done_q, dm_done_q, err_q;
  logic            any_req, tmr_clr, tmr_inc, tmr_expired;

`ifdef MEM_ARB_RR_EN
  owner_e          last_grant_q;
`endif

  assign any_req = if_req || dm_req;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) grant_d = (last_grant_q == OWN_DM) ? OWN_IF : OWN_DM;
    else                  grant_d = dm_req ? OWN_DM : OWN_IF;
`else
    grant_d = dm_req ? OWN_DM : OWN_IF;
`endif
  end

  assign tmr_clr = (state_q == IDLE) && any_req;
  assign tmr_inc = (state_q == BUSY) && !mem_ready;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= OWN_IF;
`endif
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= BUSY;
            owner_q  <= grant_d;
            mem_en_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= grant_d;
`endif
            if (grant_d == OWN_DM) begin
              mem_wr_q    <= dm_wr;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
            end else begin
              mem_wr_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          // tmr_expired already implies !mem_ready, so ready always wins.
          if (mem_ready || tmr_expired) begin
            state_q   <= DONE;
            mem_en_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            if_done_q <= (owner_q == OWN_IF);
            dm_done_q <= (owner_q == OWN_DM);
            err_q     <= !mem_ready;
            // Aborted reads return zero; writes never touch read data.
            if (!mem_wr_q) begin
              if (owner_q == OWN_DM) dm_rdata_q <= mem_ready ? mem_rdata : '0;
              else                   if_rdata_q <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign err       = err_q;
  assign if_stall  = if_req && !if_done_q;
  assign dm_stall  = dm_req && !dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request/ready traffic, checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_wr;
  logic [DW-1:0] if_addr, dm_addr, dm_wdata;
  logic          if_done, dm_done;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          mem_en, mem_wr, mem_ready;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          if_stall, dm_stall, err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [DW-1:0] exp_if_rd, exp_dm_rd;
  bit            last_dm;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .if_stall  (if_stall),
    .dm_stall  (dm_stall),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic raise_if(input logic [DW-1:0] a);
    if_req  = 1'b1;
    if_addr = a;
  endtask

  task automatic raise_dm(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d);
    dm_req   = 1'b1;
    dm_wr    = w;
    dm_addr  = a;
    dm_wdata = d;
  endtask

  // Called just after a posedge with the arbiter idle and nobody requesting.
  task automatic idle_cycle();
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = DW'($urandom);
    @(negedge clk);
    check("idle_mem_en", mem_en, 0);
    check("idle_if_done", if_done, 0);
    check("idle_dm_done", dm_done, 0);
    check("idle_err", err, 0);
    check("idle_if_rdata", if_rdata, exp_if_rd);
    check("idle_dm_rdata", dm_rdata, exp_dm_rd);
    @(posedge clk); #1;
    mem_ready = 1'b0;
  endtask

  // One full transaction. Entered just after a posedge with the arbiter idle
  // and at least one request raised; leaves just after the edge that returns
  // the arbiter to idle, with the winner's request dropped. ready arrives in
  // BUSY cycle delay+1; delay >= TO means it never arrives in time.
  task automatic serve_one(input int delay, input logic [DW-1:0] rdata, input bit drop_mid);
    bit            win_dm, exp_wr, ready_now, tmo;
    logic [DW-1:0] exp_addr, exp_wdata;
    int            busy;
    if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
      win_dm = !last_dm;
`else
      win_dm = 1'b1;
`endif
    end else begin
      win_dm = dm_req;
    end
    last_dm   = win_dm;
    exp_wr    = win_dm ? dm_wr : 1'b0;
    exp_addr  = win_dm ? dm_addr : if_addr;
    exp_wdata = dm_wdata;
    mem_ready = 1'($urandom_range(0, 1));   // idle-cycle ready must be ignored
    mem_rdata = DW'($urandom);
    @(posedge clk); #1;
    busy      = 1;
    ready_now = 1'b0;
    tmo       = 1'b0;
    forever begin
      ready_now = (busy == delay + 1);
      tmo       = !ready_now && (busy == TO);
      mem_ready = ready_now;
      mem_rdata = ready_now ? rdata : DW'($urandom);
      if (drop_mid && busy == 1) begin
        if (win_dm) dm_req = 1'b0;
        else        if_req = 1'b0;
      end
      @(negedge clk);
      check("busy_mem_en", mem_en, 1);
      check("busy_mem_wr", mem_wr, exp_wr);
      check("busy_mem_addr", mem_addr, exp_addr);
      if (exp_wr) check("busy_mem_wdata", mem_wdata, exp_wdata);
      check("busy_if_done", if_done, 0);
      check("busy_dm_done", dm_done, 0);
      check("busy_err", err, 0);
      check("busy_if_stall", if_stall, if_req);
      check("busy_dm_stall", dm_stall, dm_req);
      @(posedge clk); #1;
      if (ready_now || tmo) break;
      busy++;
    end
    if (!exp_wr) begin
      if (win_dm) exp_dm_rd = ready_now ? rdata : '0;
      else        exp_if_rd = ready_now ? rdata : '0;
    end
    mem_ready = 1'($urandom_range(0, 1));   // ready in DONE must be ignored
    mem_rdata = DW'($urandom);
    @(negedge clk);
    check("done_if_done", if_done, !win_dm);
    check("done_dm_done", dm_done, win_dm);
    check("done_err", err, tmo);
    check("done_mem_en", mem_en, 0);
    check("done_if_rdata", if_rdata, exp_if_rd);
    check("done_dm_rdata", dm_rdata, exp_dm_rd);
    check("done_if_stall", if_stall, if_req && win_dm);
    check("done_dm_stall", dm_stall, dm_req && !win_dm);
    @(posedge clk); #1;
    if (win_dm) dm_req = 1'b0;
    else        if_req = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    exp_if_rd = '0; exp_dm_rd = '0; last_dm = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_if_done", if_done, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_err", err, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // fetch read, minimum latency
    raise_if(16'h0010);
    serve_one(0, 16'h5810, 1'b0);
    idle_cycle();

    // data read, then data write that must leave dm_rdata alone
    raise_dm(1'b0, 16'h0020, 16'h0000);
    serve_one(1, 16'h1234, 1'b0);
    raise_dm(1'b1, 16'h0020, 16'h0003);
    serve_one(0, 16'hBEEF, 1'b0);
    idle_cycle();

    // simultaneous requests: winner first, loser in the very next idle
    raise_if(16'h0030);
    raise_dm(1'b0, 16'h0031, 16'h0000);
    serve_one(0, 16'hA5A5, 1'b0);
    serve_one(2, 16'h5A5A, 1'b0);
    idle_cycle();

    // ready never arrives: timeout after TO busy cycles
    raise_if(16'h0040);
    serve_one(255, 16'hFFFF, 1'b0);
    raise_dm(1'b0, 16'h0041, 16'h0000);
    serve_one(TO - 1, 16'h7777, 1'b0);     // ready on the last allowed cycle
    idle_cycle();

    // reset while BUSY aborts without a done pulse
    raise_if(16'h0077);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_mem_en", mem_en, 1);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_mem_en", mem_en, 0);
      check("abort_if_done", if_done, 0);
      check("abort_dm_done", dm_done, 0);
      check("abort_err", err, 0);
      check("abort_if_rdata", if_rdata, 0);
      check("abort_dm_rdata", dm_rdata, 0);
      check("abort_mem_addr", mem_addr, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    exp_if_rd = '0; exp_dm_rd = '0; last_dm = 1'b0;
    serve_one(0, 16'h4242, 1'b0);

    // three back-to-back ties
    raise_if(16'h0050);
    raise_dm(1'b0, 16'h0060, 16'h0000);
    serve_one(0, 16'h1111, 1'b0);
    if (!if_req) raise_if(16'h0051);
    if (!dm_req) raise_dm(1'b0, 16'h0061, 16'h0000);
    serve_one(0, 16'h2222, 1'b0);
    if (!if_req) raise_if(16'h0052);
    if (!dm_req) raise_dm(1'b1, 16'h0062, 16'h00C3);
    serve_one(0, 16'h3333, 1'b0);
    while (if_req || dm_req) serve_one(0, DW'($urandom), 1'b0);
    idle_cycle();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if (!if_req && $urandom_range(0, 2) != 0) raise_if(DW'($urandom));
      if (!dm_req && $urandom_range(0, 2) != 0)
        raise_dm(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      if (!if_req && !dm_req) idle_cycle();
      else serve_one(int'($urandom_range(0, TO + 1)), DW'($urandom), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
